uart_cmd_parser_mc: RTL
=======================

Name: uart_cmd_parser_mc

Overview:
- Parametrised successor to the single-letter UART speed-command detector.
- Consumes bytes from the UART receiver over the rdy/rdy_clr handshake and decodes frames of the form <channel letter><decimal digits><terminator>.
- Drives a per-channel duty value and direction bit to the motor PWM stage.
- Adds multi-channel addressing, saturation, digit-count limit, inter-byte timeout and error reporting.

Parameters:
- NUM_CH, 2: number of motor channels.
- DUTY_W, 8: duty width; max value 2^DUTY_W-1.
- LETTER_BASE, 8'h41 ('A'): channel k is selected by byte LETTER_BASE+k.
- MAX_DIGITS, 3: max digits per frame.
- TIMEOUT_CYC, 50_000_000: cycles allowed between bytes inside a frame (1 s at 50 MHz).

Ports:
- CLOCK_50 in 1: system clock; sole clock.
- RESET_N in 1: asynchronous, active-low reset.
- rdy in 1: receiver holds a valid byte.
- dout in 8: received byte, valid while rdy=1.
- rdy_clr out 1: one-cycle acknowledge; the receiver drops rdy on the edge where rdy_clr=1.
- DUTY out NUM_CH*DUTY_W: packed duty values; channel k occupies [k*DUTY_W +: DUTY_W].
- DIR out NUM_CH: per-channel direction; 0 = forward ('#'), 1 = reverse ('!').
- UPDATE out NUM_CH: one-cycle strobe on the channel just written.
- ERR out 1: one-cycle error strobe.
- ERR_CODE out 3: error cause; valid when ERR=1, holds last value otherwise.

Behaviour:
- Reset (async assert, sync release) sets DUTY=0, DIR=0, UPDATE=0, ERR=0, ERR_CODE=0, rdy_clr=0, state IDLE, accumulator/digit count/timer cleared.
- Reset during a frame discards the frame; no UPDATE is generated.
- dout is sampled only in a cycle where rdy=1 and the state is IDLE or DIGITS. It is never sampled while rdy=0.
- States:
  - IDLE:
    - rdy=1 and dout in [LETTER_BASE, LETTER_BASE+NUM_CH-1]: latch ch=dout-LETTER_BASE, clear acc/count/timer, go ACK with ret=DIGITS.
    - rdy=1 and any other byte: ignore silently, go ACK with ret=IDLE.
    - rdy=0: stay.
  - DIGITS, rdy=1:
    - Digit '0'..'9', count<MAX_DIGITS: acc=sat(acc*10+(dout-8'h30)); count+=1; go ACK, ret=DIGITS.
    - Digit with count==MAX_DIGITS: error TOO_LONG (3'd3), ret=IDLE.
    - '#' (8'h23) or '!' (8'h21) with count>=1: DUTY[ch]<=acc, DIR[ch]<=(dout=='!'), UPDATE[ch] pulses in the ACK cycle, ret=IDLE.
    - Terminator with count==0: error EMPTY (3'd2), no update, ret=IDLE.
    - Channel letter: error ABORT (3'd5), old frame dropped, new ch latched, acc/count/timer cleared, ret=DIGITS.
    - Any other byte: error BAD_CHAR (3'd1), ret=IDLE.
  - DIGITS, rdy=0: timer increments. When timer reaches TIMEOUT_CYC-1, signal error TIMEOUT (3'd4) and go IDLE directly without ACK, since no byte is held.
  - ACK: rdy_clr=1 for exactly this cycle, then go to ret. UPDATE and ERR pulses are issued in this cycle, or in the timeout cycle for TIMEOUT.
- rdy_clr is 0 in every state except ACK.
- Byte latency: byte present -> rdy_clr one cycle later -> next byte accepted at the earliest two cycles after the first.
- Arithmetic: acc is DUTY_W+4 bits wide; acc*10 is computed as (acc<<3)+(acc<<1).
  - If the result exceeds 2^DUTY_W-1, acc clamps to 2^DUTY_W-1 and stays clamped for the rest of the frame.
  - Saturation is not an error.
- UPDATE is one-hot or zero. ERR and UPDATE never assert in the same cycle. Unaddressed channels hold their values.
- Timer counts only in DIGITS and clears on every accepted byte.

Decomposition:
- Shared package uart_cmd_pkg holds:
  - ASCII constants: CH_DIGIT0=8'h30, CH_FWD=8'h23, CH_REV=8'h21.
  - State encoding: IDLE, DIGITS, ACK.
  - Error codes: BAD_CHAR=1, EMPTY=2, TOO_LONG=3, TIMEOUT=4, ABORT=5.
- One sub-module: dec_acc_sat. Combinational; takes acc, digit and DUTY_W, returns the saturated acc*10+digit. It is reused by future numeric parsers.

Test Plan:
- Bench config: NUM_CH=2, DUTY_W=8, TIMEOUT_CYC shortened to 100.
- Bytes "A128#" (model holds each byte until rdy_clr) -> DUTY[7:0]=128, DIR[0]=0, UPDATE=2'b01 for 1 cycle, DUTY[15:8] stays 0; rdy_clr pulses once per byte, 5 pulses total.
- "B300!" -> DUTY[15:8]=255 (saturated), DIR[1]=1, UPDATE=2'b10, ERR stays 0.
- "A12x" then "A5#" -> ERR pulse with ERR_CODE=1 on 'x', DUTY[7:0] unchanged; then DUTY[7:0]=5.
- "A#" -> ERR_CODE=2. "A1234#" -> ERR_CODE=3 on '4'; the trailing '#' is ignored in IDLE; no UPDATE.
- "A4" then 100 idle cycles -> ERR_CODE=4, state IDLE; "A4B7#" -> ERR_CODE=5 on 'B', then DUTY[15:8]=7, DUTY[7:0] unchanged.
- Reset mid-frame: "A9", RESET_N low between bytes with rdy still high -> all outputs 0 immediately with no clock edge; after release, the held byte is consumed as an IDLE byte and "#" produces no UPDATE.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command parsers: ASCII codes, FSM states, error codes.
package uart_cmd_pkg;

  localparam logic [7:0] CH_DIGIT0 = 8'h30;
  localparam logic [7:0] CH_FWD    = 8'h23;
  localparam logic [7:0] CH_REV    = 8'h21;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIGITS = 2'd1,
    ACK    = 2'd2
  } state_e;

  localparam logic [2:0] BAD_CHAR = 3'd1;
  localparam logic [2:0] EMPTY    = 3'd2;
  localparam logic [2:0] TOO_LONG = 3'd3;
  localparam logic [2:0] TIMEOUT  = 3'd4;
  localparam logic [2:0] ABORT    = 3'd5;

endpackage

// File: rtl/dec_acc_sat.sv
// Decimal accumulate step: returns min(acc*10 + digit, 2^DUTY_W-1).
module dec_acc_sat #(
  parameter int DUTY_W = 8
) (
  input  logic [DUTY_W+3:0] acc_i,
  input  logic [3:0]        digit_i,
  output logic [DUTY_W+3:0] acc_o
);

  localparam logic [DUTY_W+7:0] MAXV = {8'd0, {DUTY_W{1'b1}}};

  function automatic logic [DUTY_W+3:0] sat(input logic [DUTY_W+7:0] v);
    if (v > MAXV) sat = {4'd0, {DUTY_W{1'b1}}};
    else          sat = v[DUTY_W+3:0];
  endfunction

  logic [DUTY_W+7:0] wide;

  // Widened so the multiply-add can never wrap before the clamp sees it.
  always_comb begin
    wide  = ({4'd0, acc_i} << 3) + ({4'd0, acc_i} << 1) + {{(DUTY_W+4){1'b0}}, digit_i};
    acc_o = sat(wide);
  end

endmodule

// File: rtl/uart_cmd_parser_mc.sv
// Multi-channel UART command parser: <letter><digits><#|!> frames set per-channel duty and direction.
module uart_cmd_parser_mc
  import uart_cmd_pkg::*;
#(
  parameter int         NUM_CH      = 2,
  parameter int         DUTY_W      = 8,
  parameter logic [7:0] LETTER_BASE = 8'h41,
  parameter int         MAX_DIGITS  = 3,
  parameter int         TIMEOUT_CYC = 50_000_000
) (
  input  logic                       CLOCK_50,
  input  logic                       RESET_N,
  input  logic                       rdy,
  input  logic [7:0]                 dout,
  output logic                       rdy_clr,
  output logic [NUM_CH*DUTY_W-1:0]   DUTY,
  output logic [NUM_CH-1:0]          DIR,
  output logic [NUM_CH-1:0]          UPDATE,
  output logic                       ERR,
  output logic [2:0]                 ERR_CODE
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int TM_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int ACC_W = DUTY_W + 4;

  state_e                     state_q, state_d, ret_q, ret_d;
  logic [CH_W-1:0]            ch_q, ch_d;
  logic [ACC_W-1:0]           acc_q, acc_d, acc_mac;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [TM_W-1:0]            tmr_q, tmr_d;
  logic [NUM_CH*DUTY_W-1:0]   duty_q, duty_d;
  logic [NUM_CH-1:0]          dir_q, dir_d, upd_q, upd_d;
  logic                       err_q, err_d, clr_q, clr_d;
  logic [2:0]                 code_q, code_d;

  logic [8:0] letter_off;
  logic       is_letter, is_digit, is_term;

  assign letter_off = {1'b0, dout} - {1'b0, LETTER_BASE};
  assign is_letter  = !letter_off[8] && (letter_off < 9'(NUM_CH));
  assign is_digit   = (dout >= CH_DIGIT0) && (dout <= CH_DIGIT0 + 8'd9);
  assign is_term    = (dout == CH_FWD) || (dout == CH_REV);

  dec_acc_sat #(.DUTY_W(DUTY_W)) u_acc (
    .acc_i   (acc_q),
    .digit_i (dout[3:0]),
    .acc_o   (acc_mac)
  );

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    ch_d    = ch_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    duty_d  = duty_q;
    dir_d   = dir_q;
    upd_d   = '0;
    err_d   = 1'b0;
    code_d  = code_q;
    unique case (state_q)
      IDLE: begin
        if (rdy) begin
          state_d = ACK;
          ret_d   = IDLE;
          if (is_letter) begin
            ch_d  = letter_off[CH_W-1:0];
            acc_d = '0;
            cnt_d = '0;
            tmr_d = '0;
            ret_d = DIGITS;
          end
        end
      end
      DIGITS: begin
        if (rdy) begin
          state_d = ACK;
          ret_d   = IDLE;
          tmr_d   = '0;
          if (is_digit) begin
            if (cnt_q < CNT_W'(MAX_DIGITS)) begin
              acc_d = acc_mac;
              cnt_d = cnt_q + CNT_W'(1);
              ret_d = DIGITS;
            end else begin
              err_d  = 1'b1;
              code_d = TOO_LONG;
            end
          end else if (is_term) begin
            if (cnt_q != '0) begin
              duty_d[ch_q*DUTY_W +: DUTY_W] = acc_q[DUTY_W-1:0];
              dir_d[ch_q] = (dout == CH_REV);
              upd_d[ch_q] = 1'b1;
            end else begin
              err_d  = 1'b1;
              code_d = EMPTY;
            end
          end else if (is_letter) begin
            // A new letter mid-frame restarts parsing on the new channel.
            err_d  = 1'b1;
            code_d = ABORT;
            ch_d   = letter_off[CH_W-1:0];
            acc_d  = '0;
            cnt_d  = '0;
            ret_d  = DIGITS;
          end else begin
            err_d  = 1'b1;
            code_d = BAD_CHAR;
          end
        end else if (tmr_q == TM_W'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          code_d  = TIMEOUT;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + TM_W'(1);
        end
      end
      ACK:     state_d = ret_q;
      default: state_d = IDLE;
    endcase
    clr_d = (state_d == ACK);
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      ret_q   <= IDLE;
      ch_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      duty_q  <= '0;
      dir_q   <= '0;
      upd_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= 3'd0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      ch_q    <= ch_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
      code_q  <= code_d;
      clr_q   <= clr_d;
    end
  end

  assign rdy_clr  = clr_q;
  assign DUTY     = duty_q;
  assign DIR      = dir_q;
  assign UPDATE   = upd_q;
  assign ERR      = err_q;
  assign ERR_CODE = code_q;

endmodule
